// File: rtl/dcmac_reset_sequencer.sv
// GT/DCMAC bring-up sequencer: global reset/TX-wait FSM plus per-port RX reset FSMs with timeout and bounded retry.
// Optional per-port link-loss counters are built when DCMAC_SEQ_LINKSTAT_EN is defined.
module dcmac_reset_sequencer #(
    parameter int NUM_PORTS      = 2,
    parameter int LANES_PER_PORT = 4,
    parameter int RESET_PULSE    = 32,
    parameter int SETTLE_CYCLES  = 1024,
    parameter int TIMEOUT_CYCLES = 1048576,
    parameter int MAX_RETRIES    = 7
) (
    input  logic                              s_axi_clk,
    input  logic                              s_axi_resetn,
    input  logic [NUM_PORTS-1:0]              gtpowergood,
    input  logic [NUM_PORTS*LANES_PER_PORT-1:0] gt_rx_reset_done_out,
    input  logic [NUM_PORTS*LANES_PER_PORT-1:0] gt_tx_reset_done_out,
    input  logic                              user_gt_reset_all,
    input  logic [NUM_PORTS-1:0]              user_gt_reset_rx_datapath,
    output logic                              gtpowergood_in,
    output logic                              gt_reset_all_in,
    output logic [NUM_PORTS-1:0]              gt_reset_rx_datapath_in,
    output logic [NUM_PORTS-1:0]              gt_reset_tx_datapath_in,
    output logic [NUM_PORTS-1:0]              gt_rx_reset_done,
    output logic [NUM_PORTS-1:0]              gt_tx_reset_done,
    output logic [NUM_PORTS-1:0]              port_up,
    output logic [NUM_PORTS-1:0]              port_fail,
    output logic [4*NUM_PORTS-1:0]            retry_count,
    output logic [8*NUM_PORTS-1:0]            link_loss_count
);
    localparam int NL    = NUM_PORTS * LANES_PER_PORT;
    localparam int SW    = NUM_PORTS + 2 * NL;
    localparam int PMAX0 = (TIMEOUT_CYCLES > SETTLE_CYCLES) ? TIMEOUT_CYCLES : SETTLE_CYCLES;
    localparam int PMAX  = (PMAX0 > RESET_PULSE) ? PMAX0 : RESET_PULSE;
    localparam int CW    = (PMAX > 1) ? $clog2(PMAX) : 1;
    localparam int GMAX  = (TIMEOUT_CYCLES > RESET_PULSE) ? TIMEOUT_CYCLES : RESET_PULSE;
    localparam int GCW   = (GMAX > 1) ? $clog2(GMAX) : 1;

    localparam logic [CW-1:0]  TO_LAST   = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0]  ST_LAST   = CW'(SETTLE_CYCLES - 1);
    localparam logic [CW-1:0]  RP_LAST   = CW'(RESET_PULSE - 1);
    localparam logic [GCW-1:0] G_TO_LAST = GCW'(TIMEOUT_CYCLES - 1);
    localparam logic [GCW-1:0] G_RP_LAST = GCW'(RESET_PULSE - 1);
    localparam logic [3:0]     RETRY_MAX = 4'(MAX_RETRIES);

    typedef enum logic [1:0] {G_PWR, G_RST, G_TXW, G_RUN} g_state_t;
    typedef enum logic [2:0] {P_IDLE, P_WAIT, P_SETTLE, P_UP, P_RXRST, P_FAIL} p_state_t;

    logic [SW-1:0]        sync_q1, sync_q2;
    logic [NUM_PORTS-1:0] pg_s, rx_ok, tx_ok, rx_prev, rx_rise;
    logic [NL-1:0]        tx_s, rx_s;
    logic                 pg_all, all_prev, all_rise, glob_evt, port_run;

    always_ff @(posedge s_axi_clk or negedge s_axi_resetn) begin
        if (!s_axi_resetn) begin
            sync_q1 <= '0;
            sync_q2 <= '0;
        end else begin
            sync_q1 <= {gtpowergood, gt_tx_reset_done_out, gt_rx_reset_done_out};
            sync_q2 <= sync_q1;
        end
    end

    assign {pg_s, tx_s, rx_s} = sync_q2;
    assign pg_all = &pg_s;

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_lane_and
        assign rx_ok[p] = &rx_s[p*LANES_PER_PORT +: LANES_PER_PORT];
        assign tx_ok[p] = &tx_s[p*LANES_PER_PORT +: LANES_PER_PORT];
    end

    // Previous-value registers reset high so a level already asserted at reset is not an edge.
    always_ff @(posedge s_axi_clk or negedge s_axi_resetn) begin
        if (!s_axi_resetn) begin
            all_prev         <= 1'b1;
            rx_prev          <= '1;
            gtpowergood_in   <= 1'b0;
            gt_rx_reset_done <= '0;
            gt_tx_reset_done <= '0;
        end else begin
            all_prev         <= user_gt_reset_all;
            rx_prev          <= user_gt_reset_rx_datapath;
            gtpowergood_in   <= pg_all;
            gt_rx_reset_done <= rx_ok;
            gt_tx_reset_done <= tx_ok;
        end
    end

    assign all_rise = user_gt_reset_all & ~all_prev;
    assign rx_rise  = user_gt_reset_rx_datapath & ~rx_prev;
    assign glob_evt = ~pg_all | all_rise;

    g_state_t       g_state, g_next;
    logic [GCW-1:0] g_cnt;
    logic           g_cnt_clr;

    always_ff @(posedge s_axi_clk or negedge s_axi_resetn) begin
        if (!s_axi_resetn) begin
            g_state <= G_PWR;
            g_cnt   <= '0;
        end else begin
            g_state <= g_next;
            if (g_cnt_clr)
                g_cnt <= '0;
            else if (g_state == G_RST || g_state == G_TXW)
                g_cnt <= g_cnt + 1'b1;
        end
    end

    always_comb begin
        g_next    = g_state;
        g_cnt_clr = 1'b0;
        if (!pg_all) begin
            g_next    = G_PWR;
            g_cnt_clr = 1'b1;
        end else if (all_rise) begin
            g_next    = G_RST;
            g_cnt_clr = 1'b1;
        end else begin
            case (g_state)
                G_PWR: begin
                    g_next    = G_RST;
                    g_cnt_clr = 1'b1;
                end
                G_RST: if (g_cnt == G_RP_LAST) begin
                    g_next    = G_TXW;
                    g_cnt_clr = 1'b1;
                end
                // A TX timeout re-pulses reset_all; it is not charged to any port.
                G_TXW: if (&tx_ok) begin
                    g_next    = G_RUN;
                    g_cnt_clr = 1'b1;
                end else if (g_cnt == G_TO_LAST) begin
                    g_next    = G_RST;
                    g_cnt_clr = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign gt_reset_all_in         = (g_state == G_PWR) || (g_state == G_RST);
    assign gt_reset_tx_datapath_in = '0;
    assign port_run                = (g_state == G_RUN) && !glob_evt;

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        p_state_t      st, nx;
        logic [CW-1:0] cnt;
        logic [3:0]    retry;
        logic          cnt_clr, retry_inc, retry_clr;

        always_ff @(posedge s_axi_clk or negedge s_axi_resetn) begin
            if (!s_axi_resetn) begin
                st    <= P_IDLE;
                cnt   <= '0;
                retry <= '0;
            end else begin
                st <= nx;
                if (cnt_clr)
                    cnt <= '0;
                else if (st == P_WAIT || st == P_SETTLE || st == P_RXRST)
                    cnt <= cnt + 1'b1;
                if (glob_evt || retry_clr)
                    retry <= '0;
                else if (retry_inc)
                    retry <= retry + 1'b1;
            end
        end

        // A user restart outranks a coincident timeout, so no retry is charged then.
        always_comb begin
            nx        = st;
            cnt_clr   = 1'b0;
            retry_inc = 1'b0;
            retry_clr = 1'b0;
            if (!port_run) begin
                nx      = P_IDLE;
                cnt_clr = 1'b1;
            end else if (rx_rise[p]) begin
                nx        = P_RXRST;
                cnt_clr   = 1'b1;
                retry_clr = 1'b1;
            end else begin
                case (st)
                    P_IDLE: begin
                        nx      = P_WAIT;
                        cnt_clr = 1'b1;
                    end
                    P_WAIT: if (rx_ok[p]) begin
                        nx      = P_SETTLE;
                        cnt_clr = 1'b1;
                    end else if (cnt == TO_LAST) begin
                        cnt_clr = 1'b1;
                        if (retry == RETRY_MAX) begin
                            nx = P_FAIL;
                        end else begin
                            nx        = P_RXRST;
                            retry_inc = 1'b1;
                        end
                    end
                    P_SETTLE: if (!rx_ok[p]) begin
                        nx      = P_WAIT;
                        cnt_clr = 1'b1;
                    end else if (cnt == ST_LAST) begin
                        nx      = P_UP;
                        cnt_clr = 1'b1;
                    end
                    P_UP: if (!rx_ok[p]) begin
                        nx      = P_RXRST;
                        cnt_clr = 1'b1;
                    end
                    P_RXRST: if (cnt == RP_LAST) begin
                        nx      = P_WAIT;
                        cnt_clr = 1'b1;
                    end
                    default: ;
                endcase
            end
        end

        assign gt_reset_rx_datapath_in[p] = (st == P_RXRST);
        assign port_up[p]                 = (st == P_UP);
        assign port_fail[p]               = (st == P_FAIL);
        assign retry_count[4*p +: 4]      = retry;

`ifdef DCMAC_SEQ_LINKSTAT_EN
        logic       ll_evt;
        logic [7:0] ll_cnt;
        assign ll_evt = port_run && !rx_rise[p] && (st == P_UP) && !rx_ok[p];
        always_ff @(posedge s_axi_clk or negedge s_axi_resetn) begin
            if (!s_axi_resetn)
                ll_cnt <= '0;
            else if (glob_evt)
                ll_cnt <= '0;
            else if (ll_evt && ll_cnt != 8'hFF)
                ll_cnt <= ll_cnt + 1'b1;
        end
        assign link_loss_count[8*p +: 8] = ll_cnt;
`else
        assign link_loss_count[8*p +: 8] = 8'h00;
`endif
    end

endmodule

// File: tb/tb_dcmac_reset_sequencer.sv
// Directed bench for dcmac_reset_sequencer: sync/AND table, power-up, link loss, settle glitch, timeout/fail, priority, async reset.
module tb_dcmac_reset_sequencer;
    logic       s_axi_clk;
    logic       s_axi_resetn;
    logic [1:0] gtpowergood;
    logic [7:0] rx_in, tx_in;
    logic       user_gt_reset_all;
    logic [1:0] user_rx;
    logic       gtpowergood_in, gt_reset_all_in;
    logic [1:0] gt_reset_rx_datapath_in, gt_reset_tx_datapath_in;
    logic [1:0] gt_rx_reset_done, gt_tx_reset_done, port_up, port_fail;
    logic [7:0] retry_count;
    logic [15:0] link_loss_count;

    int n_chk = 0;
    int n_fail = 0;

`ifdef DCMAC_SEQ_LINKSTAT_EN
    localparam logic [7:0] EXP_LL = 8'd1;
`else
    localparam logic [7:0] EXP_LL = 8'd0;
`endif

    dcmac_reset_sequencer #(
        .NUM_PORTS(2), .LANES_PER_PORT(4), .RESET_PULSE(8),
        .SETTLE_CYCLES(16), .TIMEOUT_CYCLES(64), .MAX_RETRIES(3)
    ) dut (
        .s_axi_clk(s_axi_clk), .s_axi_resetn(s_axi_resetn),
        .gtpowergood(gtpowergood),
        .gt_rx_reset_done_out(rx_in), .gt_tx_reset_done_out(tx_in),
        .user_gt_reset_all(user_gt_reset_all),
        .user_gt_reset_rx_datapath(user_rx),
        .gtpowergood_in(gtpowergood_in), .gt_reset_all_in(gt_reset_all_in),
        .gt_reset_rx_datapath_in(gt_reset_rx_datapath_in),
        .gt_reset_tx_datapath_in(gt_reset_tx_datapath_in),
        .gt_rx_reset_done(gt_rx_reset_done), .gt_tx_reset_done(gt_tx_reset_done),
        .port_up(port_up), .port_fail(port_fail),
        .retry_count(retry_count), .link_loss_count(link_loss_count)
    );

    initial s_axi_clk = 1'b0;
    always #5 s_axi_clk = ~s_axi_clk;

    typedef struct packed {
        logic [1:0] pg;
        logic [7:0] tx;
        logic [7:0] rx;
        logic       pwr;
        logic [1:0] txd;
        logic [1:0] rxd;
    } vec_t;

    vec_t vecs [5];

    task automatic tick();
        @(negedge s_axi_clk);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_pwr_in"},    32'(gtpowergood_in), 32'd0);
        chk({tag, "_rst_all"},   32'(gt_reset_all_in), 32'd1);
        chk({tag, "_rx_dp"},     32'(gt_reset_rx_datapath_in), 32'd0);
        chk({tag, "_tx_dp"},     32'(gt_reset_tx_datapath_in), 32'd0);
        chk({tag, "_rx_done"},   32'(gt_rx_reset_done), 32'd0);
        chk({tag, "_tx_done"},   32'(gt_tx_reset_done), 32'd0);
        chk({tag, "_port_up"},   32'(port_up), 32'd0);
        chk({tag, "_port_fail"}, 32'(port_fail), 32'd0);
        chk({tag, "_retry"},     32'(retry_count), 32'd0);
        chk({tag, "_ll"},        32'(link_loss_count), 32'd0);
    endtask

    initial begin
        logic [1:0] prev_txd, prev_rxd;
        int rst_cyc, plen, bad_up, bad_p1, up_i, np, fail_i, last_end, bad;
        int rx_i [2];
        int pu_i [2];
        int st_i [4];
        int w_i  [4];
        logic cur, prv;

        // pg never 2'b11 here, so the FSM stays in G_PWR while sync/AND mapping is exercised.
        vecs[0] = '{pg: 2'b01, tx: 8'h0F, rx: 8'hF0, pwr: 1'b0, txd: 2'b01, rxd: 2'b10};
        vecs[1] = '{pg: 2'b10, tx: 8'h7F, rx: 8'hFE, pwr: 1'b0, txd: 2'b01, rxd: 2'b10};
        vecs[2] = '{pg: 2'b00, tx: 8'hFF, rx: 8'hFF, pwr: 1'b0, txd: 2'b11, rxd: 2'b11};
        vecs[3] = '{pg: 2'b00, tx: 8'hF8, rx: 8'h1F, pwr: 1'b0, txd: 2'b10, rxd: 2'b01};
        vecs[4] = '{pg: 2'b00, tx: 8'h00, rx: 8'h00, pwr: 1'b0, txd: 2'b00, rxd: 2'b00};

        s_axi_resetn = 1'b0;
        gtpowergood = 2'b00; rx_in = 8'h00; tx_in = 8'h00;
        user_gt_reset_all = 1'b0; user_rx = 2'b00;
        repeat (3) tick();
        chk_reset("rst");
        s_axi_resetn = 1'b1;
        repeat (2) tick();
        chk_reset("rst_rel");

        prev_txd = 2'b00; prev_rxd = 2'b00;
        for (int v = 0; v < 5; v++) begin
            gtpowergood = vecs[v].pg; tx_in = vecs[v].tx; rx_in = vecs[v].rx;
            repeat (2) tick();
            chk($sformatf("vec%0d_txd_hold", v), 32'(gt_tx_reset_done), 32'(prev_txd));
            chk($sformatf("vec%0d_rxd_hold", v), 32'(gt_rx_reset_done), 32'(prev_rxd));
            tick();
            chk($sformatf("vec%0d_txd", v), 32'(gt_tx_reset_done), 32'(vecs[v].txd));
            chk($sformatf("vec%0d_rxd", v), 32'(gt_rx_reset_done), 32'(vecs[v].rxd));
            chk($sformatf("vec%0d_pwr", v), 32'(gtpowergood_in), 32'(vecs[v].pwr));
            chk($sformatf("vec%0d_rst_all", v), 32'(gt_reset_all_in), 32'd1);
            prev_txd = vecs[v].txd; prev_rxd = vecs[v].rxd;
        end

        // Power-up: pg at t0, tx done at t0+20, rx done at t0+30.
        gtpowergood = 2'b11;
        rst_cyc = 0; rx_i = '{-1, -1}; pu_i = '{-1, -1};
        for (int i = 1; i <= 200; i++) begin
            tick();
            if (gtpowergood_in && gt_reset_all_in) rst_cyc++;
            for (int p = 0; p < 2; p++) begin
                if (gt_rx_reset_done[p] && rx_i[p] < 0) rx_i[p] = i;
                if (port_up[p] && pu_i[p] < 0) pu_i[p] = i;
            end
            if (i == 20) tx_in = 8'hFF;
            if (i == 30) rx_in = 8'hFF;
            if (pu_i[0] >= 0 && pu_i[1] >= 0) break;
        end
        chk("pwrup_rst_all_cycles", 32'(rst_cyc), 32'd8);
        chk("pwrup_port_up", 32'(port_up), 32'b11);
        chk("pwrup_settle_p0", 32'(pu_i[0] - rx_i[0]), 32'd16);
        chk("pwrup_settle_p1", 32'(pu_i[1] - rx_i[1]), 32'd16);
        chk("pwrup_retry", 32'(retry_count), 32'd0);
        chk("pwrup_rst_all_low", 32'(gt_reset_all_in), 32'd0);

        // Link loss on port0 lane 2.
        rx_in = 8'hFB;
        plen = 0; bad_up = 0; bad_p1 = 0; prv = 1'b0;
        for (int i = 1; i <= 30; i++) begin
            tick();
            cur = gt_reset_rx_datapath_in[0];
            if (cur) begin
                plen++;
                if (port_up[0]) bad_up++;
            end
            if (gt_reset_rx_datapath_in[1]) bad_p1++;
            if (prv && !cur) break;
            prv = cur;
        end
        chk("ll_pulse_len", 32'(plen), 32'd8);
        chk("ll_up_during_pulse", 32'(bad_up), 32'd0);
        chk("ll_port1_pulse", 32'(bad_p1), 32'd0);
        chk("ll_port_up", 32'(port_up), 32'b10);
        chk("ll_count", 32'(link_loss_count[7:0]), 32'(EXP_LL));
        chk("ll_retry", 32'(retry_count), 32'd0);

        // Settle glitch: recover lane, drop it once while settle count is 10.
        rx_in = 8'hFF;
        up_i = -1;
        for (int i = 1; i <= 45; i++) begin
            tick();
            if (port_up[0] && up_i < 0) up_i = i;
            if (i == 11) rx_in = 8'hFB;
            if (i == 12) rx_in = 8'hFF;
        end
        chk("glitch_up_cycle", 32'(up_i), 32'd31);
        chk("glitch_retry", 32'(retry_count), 32'd0);
        chk("glitch_ll_count", 32'(link_loss_count[7:0]), 32'(EXP_LL));

        // Timeout/fail on port1 lane 5 after a user reset_all.
        rx_in = 8'hDF; user_gt_reset_all = 1'b1;
        np = 0; prv = 1'b0; fail_i = -1; last_end = 0;
        st_i = '{0, 0, 0, 0}; w_i = '{0, 0, 0, 0};
        for (int i = 1; i <= 700; i++) begin
            tick();
            user_gt_reset_all = 1'b0;
            cur = gt_reset_rx_datapath_in[1];
            if (cur && !prv && np < 4) st_i[np] = i;
            if (!cur && prv && np < 4) begin
                w_i[np] = i - st_i[np];
                np++;
                last_end = i;
            end
            prv = cur;
            if (port_fail[1]) begin
                fail_i = i;
                break;
            end
        end
        chk("to_pulses", 32'(np), 32'd3);
        chk("to_width0", 32'(w_i[0]), 32'd8);
        chk("to_width2", 32'(w_i[2]), 32'd8);
        chk("to_space01", 32'(st_i[1] - st_i[0]), 32'd72);
        chk("to_space12", 32'(st_i[2] - st_i[1]), 32'd72);
        chk("to_fail_delay", 32'(fail_i - last_end), 32'd64);
        chk("to_port_fail", 32'(port_fail), 32'b10);
        chk("to_port_up", 32'(port_up), 32'b01);
        chk("to_retry", 32'(retry_count), 32'h30);
        chk("to_ll_cleared", 32'(link_loss_count), 32'd0);

        // User RX edge leaves FAIL and clears retries.
        tick();
        rx_in = 8'hFF; user_rx = 2'b10;
        tick();
        chk("rec_pulse", 32'(gt_reset_rx_datapath_in), 32'b10);
        chk("rec_retry", 32'(retry_count), 32'd0);
        chk("rec_fail", 32'(port_fail), 32'd0);
        for (int i = 0; i < 60; i++) begin
            tick();
            if (port_up == 2'b11) break;
        end
        chk("rec_port_up", 32'(port_up), 32'b11);
        user_rx = 2'b00;
        repeat (3) tick();

        // Priority: powergood[0] falls, user RX edge lands when the FSM sees it.
        gtpowergood = 2'b10;
        repeat (2) tick();
        chk("prio_pwr_before", 32'(gtpowergood_in), 32'd1);
        chk("prio_rst_all_before", 32'(gt_reset_all_in), 32'd0);
        user_rx = 2'b10;
        bad = 0;
        for (int i = 3; i <= 22; i++) begin
            tick();
            if (gt_reset_rx_datapath_in != 2'b00) bad++;
            if (i == 3) begin
                chk("prio_rst_all", 32'(gt_reset_all_in), 32'd1);
                chk("prio_pwr_in", 32'(gtpowergood_in), 32'd0);
                chk("prio_port_up", 32'(port_up), 32'd0);
            end
        end
        chk("prio_no_rx_pulse", 32'(bad), 32'd0);

        // Async reset in the middle of G_RST.
        gtpowergood = 2'b11; user_rx = 2'b00;
        repeat (6) tick();
        chk("grst_rst_all", 32'(gt_reset_all_in), 32'd1);
        chk("grst_pwr_in", 32'(gtpowergood_in), 32'd1);
        chk("grst_tx_done", 32'(gt_tx_reset_done), 32'b11);
        #1 s_axi_resetn = 1'b0;
        #1 chk_reset("async");
        tick();
        s_axi_resetn = 1'b1;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
